// File: rtl/apb_slave_mem_ws.sv
// APB4 completer backed by a word-addressed memory with byte strobes,
// a fixed number of wait states and PSLVERR on out-of-range addresses.
module apb_slave_mem_ws #(
  parameter int unsigned    DW          = 32,
  parameter int unsigned    AW          = 8,
  parameter int unsigned    DEPTH       = 16,
  parameter int unsigned    WAIT_STATES = 0,
  parameter logic [DW-1:0]  RESET_VAL   = '0
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [AW-1:0]    paddr,
  input  logic [DW-1:0]    pwdata,
  input  logic [DW/8-1:0]  pstrb,
  output logic [DW-1:0]    prdata,
  output logic             pready,
  output logic             pslverr
);

  localparam int unsigned NB      = DW / 8;
  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = 4;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] WS_INIT = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            pready_d, pslverr_d;
  logic [DW-1:0]   prdata_d;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            in_range_c;
  logic [IW-1:0]   idx_c;
  logic [DW-1:0]   rd_word_c;
  logic [DW-1:0]   wmask_c;
  logic            wr_en_c;

  // Range check is done on the full address so indices >= DEPTH never alias.
  assign in_range_c = ({1'b0, paddr} < DEPTH_W);
  assign idx_c      = IW'(paddr);
  assign rd_word_c  = in_range_c ? mem_q[idx_c] : '0;

  // Byte strobes expanded to a per-bit write mask.
  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign wmask_c[8*b +: 8] = {8{pstrb[b]}};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pready_d  = pready;
    pslverr_d = pslverr;
    prdata_d  = prdata;
    wr_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        // Only a genuine setup phase starts a transfer; bare penable is ignored.
        if (psel && !penable) begin
          err_d = !in_range_c;
          cnt_d = WS_INIT;
          if (WAIT_STATES == 0) begin
            state_d   = ST_ACCESS;
            pready_d  = 1'b1;
            pslverr_d = !in_range_c;
            prdata_d  = (!pwrite && in_range_c) ? rd_word_c : '0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!psel) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (penable) begin
          if (cnt_q <= CW'(1)) begin
            cnt_d     = '0;
            state_d   = ST_ACCESS;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!pwrite && !err_q) ? rd_word_c : '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      ST_ACCESS: begin
        if (!psel) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (penable) begin
          wr_en_c   = pwrite && !err_q && in_range_c;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  // Storage array: whole-array reset, masked word update on write completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[IW'(w)] <= RESET_VAL;
      end
    end else if (wr_en_c) begin
      mem_q[idx_c] <= (mem_q[idx_c] & ~wmask_c) | (pwdata & wmask_c);
    end
  end

endmodule

// File: doc/apb_slave_mem_ws.md
Name: apb_slave_mem_ws

Overview:
- Parametrised APB4 completer: word-addressed register/memory array with configurable data width, depth and fixed wait states.
- Adds byte strobes, PSLVERR on out-of-range access and clean handling of aborted transfers.
- Sits behind the APB bridge/decoder as a generic peripheral memory and a bus-protocol test target.

Parameters:
- DW, 32, data width in bits; a multiple of 8, minimum 8.
- AW, 8, paddr width; paddr is a word index.
- DEPTH, 16, number of words; 1 <= DEPTH <= 2^AW.
- WAIT_STATES, 0, ACCESS cycles with pready low before completion; range 0..15.
- RESET_VAL, 0, value loaded into every word on reset.

Ports:
- pclk  in  1  bus clock; all state updates on the rising edge.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  AW  word index.
- pwdata  in  DW  write data.
- pstrb  in  DW/8  byte write enables; bit i covers pwdata[8i+7:8i].
- prdata  out  DW  read data; valid only while pready=1 on a read.
- pready  out  1  transfer-complete, registered.
- pslverr  out  1  error response, registered; valid only while pready=1.

Behaviour:
- Reset (presetn=0, asynchronous): state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0, all words=RESET_VAL. This applies at any point, including mid-transfer.
- FSM states: IDLE, WAIT, ACCESS (ACCESS means pready=1).
- IDLE, on an edge with psel=1 and penable=0 (setup phase):
  - Latch err = (paddr >= DEPTH).
  - Load counter = WAIT_STATES.
  - If WAIT_STATES=0: go to ACCESS, set pready<=1, pslverr<=err, and prdata <= (read & !err) ? mem[paddr] : 0.
  - Otherwise: go to WAIT with pready=0.
- WAIT, with psel=1 and penable=1:
  - Decrement the counter.
  - When the counter goes 1->0: go to ACCESS, load pready, pslverr and prdata as above, using the current paddr.
  - Result: exactly WAIT_STATES cycles with pready=0 before the pready=1 cycle.
- ACCESS completes on the edge where psel=1, penable=1 and pready=1:
  - On a write with !err, each byte i with pstrb[i]=1 updates mem[paddr] byte i. Bytes with pstrb[i]=0 are unchanged.
  - pready, pslverr and prdata go to 0; state goes to IDLE.
  - pready is high for exactly one cycle per transfer.
- Back-to-back transfers: the cycle after completion may be a new setup phase; IDLE detects it in that same cycle. Maximum throughput is one transfer per 2+WAIT_STATES cycles.
- Abort: psel=0 in WAIT or ACCESS sends the FSM to IDLE on that edge. No memory write; pready, pslverr and prdata are cleared.
- penable=1 in IDLE with no preceding setup phase is ignored: no pready, no write.
- Out-of-range access: a write leaves memory untouched; a read returns prdata=0. Both complete normally with pslverr=1.
- pstrb is ignored on reads. A write with pstrb=0 completes with no data change and pslverr=0.
- prdata is 0 on write transfers and whenever pready=0.
- Addresses are never wrapped: index DEPTH and above is always an error, never an alias.

Test Plan:
- Zero-wait write/read (DW=32, DEPTH=16, WAIT_STATES=0):
  - Write addr 5, data 0x000000DC, pstrb=4'hF -> pready=1 in the first access cycle, pslverr=0.
  - Read addr 5 -> prdata=0x000000DC in the first access cycle; pready low in the following cycle.
- Wait states (WAIT_STATES=2): read addr 5 -> pready=0 for 2 access cycles, pready=1 on the 3rd. Setup-to-completion spans 4 edges; prdata=0 before pready.
- Byte strobes, after reset: write addr 3, data 0xAABBCCDD, pstrb=4'b0101 -> reading addr 3 returns 0x00BB00DD.
- Out of range (DEPTH=16):
  - Write addr 20 -> pready=1 with pslverr=1.
  - Read addr 20 -> prdata=0, pslverr=1.
  - A full sweep of addrs 0..15 is unchanged.
- Abort (WAIT_STATES=3): drop psel in the 2nd WAIT cycle of a write to addr 7 -> no pready, addr 7 still RESET_VAL. The next normal write/read to addr 7 succeeds.
- Reset mid-transfer (WAIT_STATES=3): assert presetn=0 during WAIT between clock edges -> pready, pslverr and prdata go 0 immediately, and all words read back as RESET_VAL after release.
